// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed Booth multiplier for the ALU MUL path.
// Multiplies the Y register (mplcand) by the bus value (mplier) and returns
// the full 2*WIDTH-bit signed product split into prod_hi / prod_lo.
//
// Build option: define BOOTH_RADIX4_EN for radix-4 (modified Booth)
// recoding, which halves the iteration count. Ports, reset values, handshake
// and results are the same in both builds; only latency differs.
//
// Timing, with start accepted at edge k:
//   edges k+1 .. k+ITER  perform one Booth step each
//   edge  k+ITER         loads the product, raises done, state -> DONE
//   edge  k+ITER+1       state -> IDLE, busy falls
//   edge  k+ITER+2       earliest edge at which a new start is accepted
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] mplcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             busy,
    output logic             done
);

`ifdef BOOTH_RADIX4_EN
    // Two extra accumulator bits hold +-2M without overflow.
    localparam int ACC_W = WIDTH + 2;
    localparam int ITER  = WIDTH / 2;
`else
    // One extra accumulator bit so that -M of the most negative M fits.
    localparam int ACC_W = WIDTH + 1;
    localparam int ITER  = WIDTH;
`endif
    localparam int CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Control state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Datapath state: accumulator A, multiplier shift register Q, guard q(-1),
    // and the multiplicand M pre-sign-extended to accumulator width.
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0]   mq_q,    mq_d;
    logic               qm1_q,   qm1_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;

    // Registered outputs
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Result of one Booth step applied to the current datapath state
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_step;
    logic [WIDTH-1:0]   mq_step;
    logic               qm1_step;

`ifdef BOOTH_RADIX4_EN
    // Radix-4 step: recode {q1,q0,q(-1)} into 0/+-M/+-2M, add, then shift
    // {A,Q,q(-1)} right arithmetically by two.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        addend = '0;
        case ({mq_q[1:0], qm1_q})
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = -(mcand_q << 1);
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
        sum      = acc_q + addend;
        acc_step = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        mq_step  = {sum[1:0], mq_q[WIDTH-1:2]};
        qm1_step = mq_q[1];
    end
`else
    // Radix-2 step: recode {q0,q(-1)} into 0/+M/-M, add, then shift
    // {A,Q,q(-1)} right arithmetically by one.
    always_comb begin
        addend = '0;
        case ({mq_q[0], qm1_q})
            2'b01:   addend = mcand_q;
            2'b10:   addend = -mcand_q;
            default: addend = '0;
        endcase
        sum      = acc_q + addend;
        acc_step = {sum[ACC_W-1], sum[ACC_W-1:1]};
        mq_step  = {sum[0], mq_q[WIDTH-1:1]};
        qm1_step = mq_q[0];
    end
`endif

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{(ACC_W-WIDTH){mplcand[WIDTH-1]}}, mplcand};
                    mq_d    = mplier;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                mq_d    = mq_step;
                qm1_d   = qm1_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ITER - 1)) begin
                    // The exact product always fits in 2*WIDTH bits, so the
                    // accumulator guard bits are simply dropped here.
                    prod_d  = {acc_step[WIDTH-1:0], mq_step};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy is registered and tracks the state being entered, so it is
        // high throughout RUN and DONE and low exactly when IDLE.
        busy_d = (state_d != S_IDLE);
    end

    // State register with synchronous clear; clr aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (clr) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
    assign prod_lo = prod_q[WIDTH-1:0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
